// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared UDP transmit types, header field widths and pattern constants
package udp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_GAP     = 2'd3
   } tx_state_t;

   localparam int UDP_HDR_BYTES   = 8;
   localparam int DEFAULT_TTL     = 64;
   localparam int MIN_PATTERN_LEN = 4;

   localparam int IP_ADDR_W  = 32;
   localparam int IP_DSCP_W  = 6;
   localparam int IP_ECN_W   = 2;
   localparam int IP_TTL_W   = 8;
   localparam int UDP_PORT_W = 16;
   localparam int UDP_LEN_W  = 16;
   localparam int UDP_CSUM_W = 16;

   typedef logic [UDP_LEN_W-1:0] udp_len_t;

   // Short datagrams still carry the full sequence number.
   function automatic udp_len_t clamp_len(input udp_len_t len, input udp_len_t max_len);
      udp_len_t res;
      if (len < udp_len_t'(MIN_PATTERN_LEN))
         res = udp_len_t'(MIN_PATTERN_LEN);
      else if (len > max_len)
         res = max_len;
      else
         res = len;
      return res;
   endfunction

endpackage

// File: rtl/udp_pattern_tx_if.sv
// rtl/udp_pattern_tx_if.sv - UDP header handshake plus 8-bit payload stream
interface udp_pattern_tx_if;
   import udp_pkg::*;

   logic                  hdr_valid;
   logic                  hdr_ready;
   logic [IP_DSCP_W-1:0]  hdr_ip_dscp;
   logic [IP_ECN_W-1:0]   hdr_ip_ecn;
   logic [IP_TTL_W-1:0]   hdr_ip_ttl;
   logic [IP_ADDR_W-1:0]  hdr_ip_dest_ip;
   logic [UDP_PORT_W-1:0] hdr_source_port;
   logic [UDP_PORT_W-1:0] hdr_dest_port;
   logic [UDP_LEN_W-1:0]  hdr_length;
   logic [UDP_CSUM_W-1:0] hdr_checksum;
   logic [7:0]            tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (
      output hdr_valid, hdr_ip_dscp, hdr_ip_ecn, hdr_ip_ttl, hdr_ip_dest_ip,
             hdr_source_port, hdr_dest_port, hdr_length, hdr_checksum,
             tdata, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );

   modport slave (
      input  hdr_valid, hdr_ip_dscp, hdr_ip_ecn, hdr_ip_ttl, hdr_ip_dest_ip,
             hdr_source_port, hdr_dest_port, hdr_length, hdr_checksum,
             tdata, tvalid, tlast, tuser,
      output hdr_ready, tready
   );

endinterface

// File: rtl/udp_pattern_tx.sv
// rtl/udp_pattern_tx.sv - autonomous UDP datagram source: sequence number then incrementing bytes
module udp_pattern_tx
   import udp_pkg::*;
#(
   parameter logic [15:0] DEFAULT_PORT = 16'd5000,
   parameter int          MAX_PAYLOAD  = 1472,
   parameter int          GAP_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [31:0]          cfg_dest_ip,
   input  logic [15:0]          cfg_dest_port,
   input  logic [15:0]          cfg_payload_len,
   input  logic [GAP_WIDTH-1:0] cfg_gap,
   udp_pattern_tx_if.master     tx,
   output logic                 busy,
   output logic [31:0]          pkt_count
);

   localparam udp_len_t MAX_LEN = udp_len_t'(MAX_PAYLOAD);

   tx_state_t             r_state;
   tx_state_t             w_state_nxt;
   logic                  r_hdr_valid;
   logic [31:0]           r_dest_ip;
   logic [15:0]           r_dest_port;
   udp_len_t              r_len;
   udp_len_t              r_hdr_length;
   udp_len_t              r_idx;
   logic [7:0]            r_tdata;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic [31:0]           r_seq;
   logic [31:0]           r_pkt_count;
   logic [GAP_WIDTH-1:0]  r_gap;

   logic                  w_hdr_fire;
   logic                  w_beat_fire;
   logic                  w_latch;
   udp_len_t              w_len_clamped;
   udp_len_t              w_idx_inc;
   logic                  w_hdr_valid_nxt;
   udp_len_t              w_idx_nxt;
   logic [7:0]            w_tdata_nxt;
   logic                  w_tvalid_nxt;
   logic                  w_tlast_nxt;
   logic [31:0]           w_seq_nxt;
   logic [31:0]           w_pkt_nxt;
   logic [GAP_WIDTH-1:0]  w_gap_nxt;

   function automatic logic [7:0] pattern_byte(input logic [31:0] seq, input udp_len_t idx);
      udp_len_t off;
      off = idx - udp_len_t'(MIN_PATTERN_LEN);
      case (idx)
         16'd0:   pattern_byte = seq[31:24];
         16'd1:   pattern_byte = seq[23:16];
         16'd2:   pattern_byte = seq[15:8];
         16'd3:   pattern_byte = seq[7:0];
         default: pattern_byte = off[7:0];
      endcase
   endfunction

   assign w_hdr_fire    = r_hdr_valid & tx.hdr_ready;
   assign w_beat_fire   = r_tvalid & tx.tready;
   assign w_len_clamped = clamp_len(cfg_payload_len, MAX_LEN);
   assign w_idx_inc     = r_idx + 16'd1;

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:    if (enable) w_state_nxt = ST_HDR;
         ST_HDR:     if (w_hdr_fire) w_state_nxt = ST_PAYLOAD;
         ST_PAYLOAD: if (w_beat_fire && r_tlast) w_state_nxt = ST_GAP;
         ST_GAP:     if (r_gap == '0) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of every registered output; nothing here drives a port directly.
   always_comb begin
      w_latch         = 1'b0;
      w_hdr_valid_nxt = r_hdr_valid;
      w_idx_nxt       = r_idx;
      w_tdata_nxt     = r_tdata;
      w_tvalid_nxt    = r_tvalid;
      w_tlast_nxt     = r_tlast;
      w_seq_nxt       = r_seq;
      w_pkt_nxt       = r_pkt_count;
      w_gap_nxt       = r_gap;
      unique case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_latch         = 1'b1;
               w_hdr_valid_nxt = 1'b1;
            end
         end
         ST_HDR: begin
            if (w_hdr_fire) begin
               w_hdr_valid_nxt = 1'b0;
               w_idx_nxt       = '0;
               w_tvalid_nxt    = 1'b1;
               w_tdata_nxt     = pattern_byte(r_seq, '0);
               w_tlast_nxt     = 1'b0;
            end
         end
         ST_PAYLOAD: begin
            if (w_beat_fire) begin
               if (r_tlast) begin
                  w_tvalid_nxt = 1'b0;
                  w_tlast_nxt  = 1'b0;
                  w_seq_nxt    = r_seq + 32'd1;
                  w_pkt_nxt    = r_pkt_count + 32'd1;
                  w_gap_nxt    = cfg_gap;
               end else begin
                  w_idx_nxt   = w_idx_inc;
                  w_tdata_nxt = pattern_byte(r_seq, w_idx_inc);
                  w_tlast_nxt = (w_idx_inc == r_len - 16'd1);
               end
            end
         end
         ST_GAP: begin
            if (r_gap != '0) w_gap_nxt = r_gap - 1'b1;
         end
         default: begin
            w_hdr_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hdr_valid  <= 1'b0;
         r_dest_ip    <= '0;
         r_dest_port  <= '0;
         r_len        <= '0;
         r_hdr_length <= '0;
         r_idx        <= '0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
         r_seq        <= '0;
         r_pkt_count  <= '0;
         r_gap        <= '0;
      end else begin
         if (w_latch) begin
            r_dest_ip    <= cfg_dest_ip;
            r_dest_port  <= cfg_dest_port;
            r_len        <= w_len_clamped;
            r_hdr_length <= w_len_clamped + udp_len_t'(UDP_HDR_BYTES);
         end
         r_hdr_valid <= w_hdr_valid_nxt;
         r_idx       <= w_idx_nxt;
         r_tdata     <= w_tdata_nxt;
         r_tvalid    <= w_tvalid_nxt;
         r_tlast     <= w_tlast_nxt;
         r_seq       <= w_seq_nxt;
         r_pkt_count <= w_pkt_nxt;
         r_gap       <= w_gap_nxt;
      end
   end

   assign tx.hdr_valid       = r_hdr_valid;
   assign tx.hdr_ip_dscp     = '0;
   assign tx.hdr_ip_ecn      = '0;
   assign tx.hdr_ip_ttl      = IP_TTL_W'(DEFAULT_TTL);
   assign tx.hdr_ip_dest_ip  = r_dest_ip;
   assign tx.hdr_source_port = DEFAULT_PORT;
   assign tx.hdr_dest_port   = r_dest_port;
   assign tx.hdr_length      = r_hdr_length;
   assign tx.hdr_checksum    = '0;
   assign tx.tdata           = r_tdata;
   assign tx.tvalid          = r_tvalid;
   assign tx.tlast           = r_tlast;
   assign tx.tuser           = 1'b0;

   assign busy      = (r_state != ST_IDLE);
   assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_udp_pattern_tx.sv
// tb/tb_udp_pattern_tx.sv - directed/random bench for udp_pattern_tx with a byte-level datagram model
module tb_udp_pattern_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] cfg_dest_ip = '0;
   logic [15:0] cfg_dest_port = '0;
   logic [15:0] cfg_payload_len = '0;
   logic [31:0] cfg_gap = '0;
   logic        busy;
   logic [31:0] pkt_count;

   udp_pattern_tx_if txif ();

   udp_pattern_tx #(
      .DEFAULT_PORT (16'd5000),
      .MAX_PAYLOAD  (1472),
      .GAP_WIDTH    (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .cfg_dest_ip     (cfg_dest_ip),
      .cfg_dest_port   (cfg_dest_port),
      .cfg_payload_len (cfg_payload_len),
      .cfg_gap         (cfg_gap),
      .tx              (txif),
      .busy            (busy),
      .pkt_count       (pkt_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_pass = 0;
   int unsigned m_seq = 0;
   int unsigned m_pkts = 0;
   int unsigned last_t_hdr = 0;
   logic [7:0]  cap [0:1471];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Datagram content from first principles: big-endian sequence, then (i-4) mod 256.
   function automatic logic [7:0] exp_byte(input int unsigned seq, input int i);
      if (i < 4) return 8'((seq >> (8 * (3 - i))) & 32'hFF);
      return 8'((i - 4) % 256);
   endfunction

   task automatic do_packet(input int exp_len, input int hdr_stall, input int rdy_pct,
                            input bit drop_en, input int gap, input string tag);
      int w, idx, bad, first_bad, tl_bad, unstable, busy_n;
      logic [7:0]  bad_obs, bad_exp, p_data;
      logic        p_last, p_stall, done;
      logic [31:0] h_ip;
      logic [15:0] h_port, h_len;
      w = 0;
      while (txif.hdr_valid !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check({tag, " hdr_valid"}, 64'(txif.hdr_valid), 64'd1);
      last_t_hdr = cyc;
      check({tag, " hdr_length"}, 64'(txif.hdr_length), 64'(exp_len + 8));
      check({tag, " hdr_dest_port"}, 64'(txif.hdr_dest_port), 64'(cfg_dest_port));
      check({tag, " hdr_dest_ip"}, 64'(txif.hdr_ip_dest_ip), 64'(cfg_dest_ip));
      check({tag, " hdr_consts"},
            {txif.hdr_source_port, txif.hdr_ip_ttl, txif.hdr_ip_dscp, txif.hdr_ip_ecn,
             txif.hdr_checksum, txif.tuser},
            {16'd5000, 8'd64, 6'd0, 2'd0, 16'd0, 1'b0});
      if (hdr_stall > 0) begin
         txif.hdr_ready = 1'b0;
         h_ip = txif.hdr_ip_dest_ip;
         h_port = txif.hdr_dest_port;
         h_len = txif.hdr_length;
         unstable = 0;
         for (int k = 0; k < hdr_stall; k++) begin
            @(negedge clk);
            if (txif.hdr_valid !== 1'b1 || txif.hdr_ip_dest_ip !== h_ip ||
                txif.hdr_dest_port !== h_port || txif.hdr_length !== h_len ||
                txif.tvalid !== 1'b0 || busy !== 1'b1)
               unstable++;
         end
         check({tag, " hdr stall stable"}, 64'(unstable), 64'd0);
         txif.hdr_ready = 1'b1;
      end
      idx = 0; bad = 0; first_bad = 0; tl_bad = 0; unstable = 0; w = 0;
      bad_obs = '0; bad_exp = '0; p_data = '0; p_last = 1'b0;
      p_stall = 1'b0; done = 1'b0;
      while (!done && w < 20000) begin
         @(negedge clk);
         w++;
         if (drop_en && idx == 2) enable = 1'b0;
         if (p_stall && (txif.tvalid !== 1'b1 || txif.tdata !== p_data || txif.tlast !== p_last))
            unstable++;
         txif.tready = ($urandom_range(99) < rdy_pct);
         p_stall = (txif.tvalid === 1'b1) && !txif.tready;
         p_data = txif.tdata;
         p_last = txif.tlast;
         if (txif.tvalid === 1'b1 && txif.tready) begin
            if (idx < 1472) cap[idx] = txif.tdata;
            if (txif.tdata !== exp_byte(m_seq, idx)) begin
               if (bad == 0) begin
                  first_bad = idx;
                  bad_obs = txif.tdata;
                  bad_exp = exp_byte(m_seq, idx);
               end
               bad++;
            end
            if (txif.tlast !== (idx == exp_len - 1)) tl_bad++;
            if (txif.tlast === 1'b1) done = 1'b1;
            idx++;
            if (idx > exp_len) done = 1'b1;
         end
      end
      txif.tready = 1'b1;
      check({tag, " beat count"}, 64'(idx), 64'(exp_len));
      if (bad != 0)
         $display("  %s first bad byte index %0d: observed %02h expected %02h", tag, first_bad, bad_obs, bad_exp);
      check({tag, " payload bytes"}, 64'(bad), 64'd0);
      check({tag, " tlast position"}, 64'(tl_bad), 64'd0);
      check({tag, " stall stability"}, 64'(unstable), 64'd0);
      m_seq++;
      m_pkts++;
      @(negedge clk);
      check({tag, " pkt_count"}, 64'(pkt_count), 64'(m_pkts));
      busy_n = 0;
      while (busy === 1'b1 && busy_n < gap + 50) begin
         busy_n++;
         @(negedge clk);
      end
      check({tag, " gap cycles"}, 64'(busy_n), 64'(gap + 1));
   endtask

   task automatic expect_idle(input string tag);
      int hv;
      hv = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (txif.hdr_valid !== 1'b0 || busy !== 1'b0) hv++;
      end
      check({tag, " stays idle"}, 64'(hv), 64'd0);
      check({tag, " idle pkt_count"}, 64'(pkt_count), 64'(m_pkts));
   endtask

   initial begin
      int unsigned t0;
      int k, w;
      txif.hdr_ready = 1'b1;
      txif.tready = 1'b1;
      repeat (5) @(negedge clk);
      check("reset outputs",
            {txif.hdr_valid, txif.tvalid, txif.tlast, busy},
            4'b0000);
      check("reset pkt_count", 64'(pkt_count), 64'd0);
      check("reset hdr fields",
            {txif.hdr_length, txif.hdr_dest_port, txif.hdr_ip_dest_ip}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post-reset idle", {txif.hdr_valid, busy}, 2'b00);

      cfg_dest_ip = 32'h0A00_0001;
      cfg_dest_port = 16'd1234;
      cfg_payload_len = 16'd8;
      cfg_gap = 32'd0;
      enable = 1'b1;
      do_packet(8, 0, 100, 1'b0, 0, "len8 p0");
      check("len8 p0 first bytes", {cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], cap[7]},
            64'h0000_0000_0001_0203);
      t0 = last_t_hdr;
      do_packet(8, 0, 100, 1'b0, 0, "len8 p1");
      check("len8 p1 seq", {cap[0], cap[1], cap[2], cap[3]}, 32'h0000_0001);
      check("len8 hdr spacing", 64'(last_t_hdr - t0), 64'd11);
      do_packet(8, 0, 100, 1'b1, 0, "len8 p2 drop");
      expect_idle("len8 drop");

      cfg_dest_ip = 32'hC0A8_0105;
      cfg_dest_port = 16'd9;
      cfg_payload_len = 16'd2;
      cfg_gap = 32'd3;
      enable = 1'b1;
      do_packet(4, 0, 100, 1'b1, 3, "len2 clamp");

      cfg_payload_len = 16'd2000;
      cfg_gap = 32'd0;
      enable = 1'b1;
      do_packet(1472, 0, 100, 1'b1, 0, "len2000 clamp");

      cfg_dest_port = 16'hBEEF;
      cfg_payload_len = 16'd300;
      cfg_gap = 32'd1;
      enable = 1'b1;
      do_packet(300, 20, 50, 1'b1, 1, "len300 rand");
      check("len300 byte 259", 64'(cap[259]), 64'hFF);
      check("len300 byte 260", 64'(cap[260]), 64'h00);
      expect_idle("len300 drop");

      cfg_payload_len = 16'd8;
      cfg_gap = 32'd10;
      enable = 1'b1;
      do_packet(8, 0, 100, 1'b0, 10, "gap10 p0");
      t0 = last_t_hdr;
      do_packet(8, 0, 100, 1'b1, 10, "gap10 p1");
      check("gap10 hdr spacing", 64'(last_t_hdr - t0), 64'd21);
      expect_idle("gap10 drop");

      cfg_payload_len = 16'd16;
      cfg_gap = 32'd0;
      enable = 1'b1;
      w = 0;
      while (txif.hdr_valid !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("rst hdr_valid", 64'(txif.hdr_valid), 64'd1);
      k = 0;
      w = 0;
      while (k < 3 && w < 100) begin
         @(negedge clk);
         w++;
         if (txif.tvalid === 1'b1) k++;
      end
      @(negedge clk);
      check("rst beat3 data", 64'(txif.tdata), 64'(exp_byte(m_seq, 3)));
      reset = 1'b1;
      @(negedge clk);
      check("rst mid-packet valids", {txif.hdr_valid, txif.tvalid, txif.tlast, busy}, 4'b0000);
      check("rst mid-packet pkt_count", 64'(pkt_count), 64'd0);
      check("rst mid-packet hdr_length", 64'(txif.hdr_length), 64'd0);
      reset = 1'b0;
      m_seq = 0;
      m_pkts = 0;
      do_packet(16, 0, 100, 1'b1, 0, "post-rst");
      check("post-rst seq", {cap[0], cap[1], cap[2], cap[3]}, 32'h0000_0000);
      expect_idle("post-rst drop");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/udp_pattern_tx.md
Name: udp_pattern_tx

Overview:
- Autonomous UDP datagram source for link bring-up and throughput tests.
- Sits on the UDP transmit side of the UDP/IP stack, alongside or in place of the loopback path. It drives the UDP transmit header handshake and the 8-bit AXI-Stream payload.
- Each datagram carries a 32-bit sequence number followed by an incrementing byte pattern, so a far-end checker can detect loss and corruption.

Parameters:
- DEFAULT_PORT, 16'd5000: source port used for every datagram.
- MAX_PAYLOAD, 1472: upper clamp on payload bytes (no IP fragmentation).
- GAP_WIDTH, 32: width of the inter-packet gap counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  when high, datagrams are generated back to back, separated by cfg_gap
- cfg_dest_ip  in  32  destination IP
- cfg_dest_port  in  16  destination UDP port
- cfg_payload_len  in  16  payload bytes; clamped to [4, MAX_PAYLOAD]
- cfg_gap  in  GAP_WIDTH  idle cycles between the last payload beat and the next header
- hdr_valid  out  1  UDP header valid
- hdr_ready  in  1  UDP header ready
- hdr_ip_dscp  out  6  constant 0
- hdr_ip_ecn  out  2  constant 0
- hdr_ip_ttl  out  8  constant 64
- hdr_ip_dest_ip  out  32  latched cfg_dest_ip
- hdr_source_port  out  16  DEFAULT_PORT
- hdr_dest_port  out  16  latched cfg_dest_port
- hdr_length  out  16  latched clamped length + 8
- hdr_checksum  out  16  constant 0
- tdata  out  8  payload byte
- tvalid  out  1  payload valid
- tready  in  1  payload ready
- tlast  out  1  last payload byte
- tuser  out  1  constant 0
- busy  out  1  high in any state other than IDLE
- pkt_count  out  32  datagrams fully sent (tlast handshake); wraps

Behaviour:
- Reset values: state IDLE; all valids 0; tlast 0; seq 0; pkt_count 0; gap counter 0; header field registers 0.
- States: IDLE, HDR, PAYLOAD, GAP.
- IDLE:
  - If enable=1, latch cfg_dest_ip, cfg_dest_port and the clamped length into registers.
  - Set hdr_valid=1 on the next cycle and go to HDR.
  - Config changes take effect only at this latch point.
- HDR:
  - hdr_valid and all header fields are held stable until hdr_valid&&hdr_ready.
  - On that handshake: hdr_valid falls, byte index resets to 0, tvalid rises next cycle, go to PAYLOAD.
- PAYLOAD:
  - Beat i advances only on tvalid&&tready; tdata, tvalid and tlast hold otherwise.
  - Bytes 0..3 carry seq[31:24], seq[23:16], seq[15:8], seq[7:0] (big-endian).
  - Byte i≥4 carries (i-4) mod 256.
  - tlast=1 exactly on byte index len-1.
  - On the tlast handshake: seq increments (wraps at 2^32), pkt_count increments, gap counter loads cfg_gap, go to GAP.
- GAP:
  - Counter decrements once per cycle; at 0, go to IDLE.
  - cfg_gap=0 means IDLE on the next cycle. Minimum header-to-header spacing is then HDR + len + 2 cycles.
- enable deasserted mid-packet: the current datagram completes (header and full payload). The block returns to IDLE and stays there. An AXIS frame is never truncated.
- Length clamping: len<4 becomes 4; len>MAX_PAYLOAD becomes MAX_PAYLOAD. hdr_length = len+8, computed in 16 bits with no overflow (MAX_PAYLOAD+8 < 2^16).
- Reset mid-packet: immediate return to reset values; the downstream UDP block is reset by the same signal.
- No combinational path from hdr_ready or tready to any output. All outputs are registered.

Decomposition:
- Shared package (udp_pkg): state enum, UDP_HDR_BYTES=8, DEFAULT_TTL=64, and a MIN_PATTERN_LEN=4 constant. The existing UDP header field widths also belong in this package.
- No sub-module. The byte-index/pattern mux is small enough to stay inline.

Test Plan:
- enable=1, len=8, gap=0, ready always 1:
  - One header with hdr_length=16 and hdr_dest_port=cfg.
  - Payload 00 00 00 00 00 01 02 03, tlast on the 8th beat.
  - Second packet begins with 00 00 00 01.
- len=2 → hdr_length=12, payload is 4 bytes (seq only). len=2000 with MAX_PAYLOAD=1472 → 1472 bytes, hdr_length=1480.
- Random tready (50%), len=300:
  - Data byte sequence is unchanged from the ready-always case.
  - tdata, tvalid and tlast stay stable while stalled.
  - The byte at index 259 is 0xFF and the byte at index 260 is 0x00 (pattern wrap).
- hdr_ready held 0 for 20 cycles: hdr_valid and all fields stay stable, no payload beats appear, busy=1.
- gap=10 → exactly 10 idle cycles between the tlast handshake and the return to IDLE. Drop enable during the payload → the packet completes, then no further hdr_valid; pkt_count=1.
- Assert reset at payload beat 3 → next cycle all valids are 0 and pkt_count=0. After release, the first packet restarts at seq 0.
